scan_link_ctrl: RTL and testbench
=================================

SCAN_LINK_CTRL -- requirements
Module: scan_link_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 10: buffer capacity in fill units (2..255).
REQ-002 SHALL have parameter THR_READY, default 7: fill level that triggers the CMD_READY command.
REQ-003 SHALL have parameter THR_START, default 8: fill level that triggers CMD_START (THR_READY < THR_START < DEPTH).
REQ-004 SHALL have parameter DIV, default 8: clk cycles per fill tick (>= 1).
REQ-005 SHALL have parameter CMD_W, default 8: command frame width in bits.
REQ-006 SHALL have parameter DATA_W, default 8: data frame width in bits (>= width of fill).
REQ-007 SHALL have port clk, input, 1: clock.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high; clock clk.
REQ-009 SHALL have port start_i, input, 1: peer request to start scanning.
REQ-010 SHALL have port peer_ready_i, input, 1: peer ready to accept a transfer.
REQ-011 SHALL have port peer_half_i, input, 1: peer buffer has reached 50%.
REQ-012 SHALL have port ser_clk_o, output, 1: serial link clock.
REQ-013 SHALL have port ser_data_o, output, 1: serial link data.
REQ-014 SHALL have port ser_busy_o, output, 1: high while a frame is in flight.
REQ-015 SHALL have port state_o, output, 2: current state (IDLE=0, ACTIVE=1, STANDBY=2, TRANSFER=3).
REQ-016 SHALL have port fill_o, output, $clog2(DEPTH+1): current fill level.

Function
REQ-017 SHALL transition IDLE->ACTIVE on the first clk edge at which start_i=1.
REQ-018 SHALL run a DIV-cycle divider in ACTIVE only; each wrap is one fill tick that increments fill by 1.
REQ-019 SHALL stall the fill tick while a command is pending or ser_busy_o=1; fill does not advance and the divider holds.
REQ-020 SHALL, when fill reaches THR_READY, THR_START or DEPTH, queue CMD_READY=2, CMD_START=3 or CMD_FULL=4 respectively, exactly once per level.
REQ-021 SHALL, at fill==DEPTH once CMD_FULL has completed, go to TRANSFER if peer_ready_i=1, else to STANDBY.
REQ-022 SHALL move STANDBY->TRANSFER when peer_ready_i=1 or peer_half_i=1.
REQ-023 SHALL, in TRANSFER, send a CMD_DATA=7 frame (CMD_W bits) immediately followed by a data frame of fill zero-extended to DATA_W bits, then clear fill and go to IDLE.
REQ-024 SHALL, if peer_half_i=1 in TRANSFER before the CMD_DATA frame starts, send nothing, clear fill and go to IDLE in the next cycle.
REQ-025 SHALL, if peer_half_i=1 mid-frame, complete both frames (no truncated frames), then clear fill and go to IDLE.
REQ-026 SHALL serialise LSB first, 2 clk cycles per bit: ser_data_o changes with ser_clk_o=0 on the first cycle and holds with ser_clk_o=1 on the second.
REQ-027 SHALL start a frame on the cycle after it is queued and SHALL assert ser_busy_o from the first bit cycle through the last.
REQ-028 SHALL hold ser_clk_o=0 and ser_data_o=0 while idle.
REQ-029 SHALL ignore start_i outside IDLE.

Reset
REQ-030 SHALL, on rst, set state IDLE, fill 0, divider 0, pending cleared, ser_clk_o=0, ser_data_o=0, ser_busy_o=0, including mid-frame (the frame is abandoned).

Configuration
REQ-031 SHALL, with SCAN_LINK_PARITY_EN defined, append one even-parity bit after every frame (CMD_W+1 or DATA_W+1 bits); without it, frames are exactly CMD_W/DATA_W bits.

Structure
REQ-032 SHALL take the state encoding and the command codes (2, 3, 4, 7) from shared package scan_link_pkg.
REQ-033 SHALL place the serialiser in sub-module scan_link_ser_tx (load, width select, busy, ser_clk, ser_data).

Verification
REQ-034 SHALL cover: DEPTH=10, DIV=4, start_i pulse -> CMD_READY frame 0x02 at fill 7, 0x03 at fill 8, 0x04 at fill 10, each bit on a 2-cycle clock.
REQ-035 SHALL cover: peer_ready_i=1 at fill 10 -> 0x07 frame then data 0x0A, fill_o=0, state_o=0.
REQ-036 SHALL cover: peer_ready_i=0 at full -> STANDBY held 50 cycles; peer_half_i pulse -> TRANSFER, frames 0x07, 0x0A.
REQ-037 SHALL cover: peer_half_i asserted on the 3rd bit of the 0x07 frame -> both frames complete, then IDLE with fill 0.
REQ-038 SHALL cover: rst during bit 4 of CMD_START -> ser_busy_o=0, ser_data_o=0 on the next cycle, state IDLE, fill 0.
REQ-039 SHALL cover: SCAN_LINK_PARITY_EN defined, CMD_START -> bits 1,1,0,0,0,0,0,0 then parity 0 (9 bits, 18 cycles).

Source files
------------

// File: rtl/scan_link_pkg.sv
// scan_link_pkg
//   Shared definitions for the scan link controller: FSM state encoding
//   (also driven out on state_o), transfer sub-steps, command codes and
//   the parity-bit count selected by the SCAN_LINK_PARITY_EN build macro.
package scan_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_STANDBY  = 2'd2,
    ST_TRANSFER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    XS_START = 2'd0,
    XS_CMD   = 2'd1,
    XS_DATA  = 2'd2
  } xstep_t;

  localparam int CMD_READY = 2;
  localparam int CMD_START = 3;
  localparam int CMD_FULL  = 4;
  localparam int CMD_DATA  = 7;

`ifdef SCAN_LINK_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

endpackage

// File: rtl/scan_link_ser_tx.sv
// scan_link_ser_tx
//   LSB-first frame serialiser, two clk cycles per bit (ser_clk low then
//   high, data stable across both). A load while the last bit is still
//   being held chains the next frame with no idle gap.
//   Build macro SCAN_LINK_PARITY_EN appends one even-parity bit per frame.
// Ports:
//   clk, rst      clock, synchronous active-high reset (abandons a frame)
//   i_load        capture i_word and start a frame next cycle
//   i_sel_data    width select: 0 = CMD_W bits, 1 = DATA_W bits
//   i_word        frame payload, zero-extended above the selected width
//   o_busy        high from first bit cycle through last
//   o_last        high on the final cycle of the final bit
//   o_ser_clk     serial clock
//   o_ser_data    serial data
module scan_link_ser_tx
  import scan_link_pkg::*;
#(
  parameter int CMD_W  = 8,
  parameter int DATA_W = 8,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_sel_data,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_busy,
  output logic              o_last,
  output logic              o_ser_clk,
  output logic              o_ser_data
);

  localparam int SW = WORD_W + PAR_BITS;
  localparam int CW = $clog2(SW + 1);
  localparam logic [CW-1:0] CMD_LEN  = CW'(CMD_W + PAR_BITS);
  localparam logic [CW-1:0] DATA_LEN = CW'(DATA_W + PAR_BITS);

  logic [SW-1:0] r_shift;
  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          r_busy;
  logic [SW-1:0] w_frame;

  // Parity lands just above the selected payload width so it shifts out last.
  always_comb begin
    w_frame = SW'(i_word);
`ifdef SCAN_LINK_PARITY_EN
    if (i_sel_data) w_frame[DATA_W] = ^i_word;
    else            w_frame[CMD_W]  = ^i_word;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_busy  <= 1'b0;
    end else if (i_load) begin
      r_shift <= w_frame;
      r_cnt   <= i_sel_data ? DATA_LEN : CMD_LEN;
      r_phase <= 1'b0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (!r_phase) begin
        r_phase <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) r_busy <= 1'b0;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_last     = r_busy & r_phase & (r_cnt == CW'(1));
  assign o_ser_clk  = r_busy & r_phase;
  assign o_ser_data = r_busy & r_shift[0];

endmodule

// File: rtl/scan_link_ctrl.sv
// scan_link_ctrl
//   Fill-level driven scan link controller. A start request begins filling
//   at one unit per DIV clk cycles; crossing THR_READY, THR_START and DEPTH
//   each sends one command frame. When full, fill is sent to the peer as a
//   CMD_DATA frame followed by a data frame, then the controller idles.
//   Build macro SCAN_LINK_PARITY_EN (see scan_link_ser_tx) adds frame parity.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start_i        peer start request (honoured in IDLE only)
//   peer_ready_i   peer can accept a transfer
//   peer_half_i    peer buffer at 50%
//   ser_clk_o      serial clock
//   ser_data_o     serial data
//   ser_busy_o     frame in flight
//   state_o        IDLE=0 ACTIVE=1 STANDBY=2 TRANSFER=3
//   fill_o         current fill level
//
// state    | meaning
// IDLE     | waiting for start_i, fill held at 0
// ACTIVE   | filling; threshold commands sent as levels are reached
// STANDBY  | full, waiting for peer_ready_i or peer_half_i
// TRANSFER | sending CMD_DATA + fill, or dropping it on an early peer_half_i
module scan_link_ctrl
  import scan_link_pkg::*;
#(
  parameter int DEPTH     = 10,
  parameter int THR_READY = 7,
  parameter int THR_START = 8,
  parameter int DIV       = 8,
  parameter int CMD_W     = 8,
  parameter int DATA_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         peer_ready_i,
  input  logic                         peer_half_i,
  output logic                         ser_clk_o,
  output logic                         ser_data_o,
  output logic                         ser_busy_o,
  output logic [1:0]                   state_o,
  output logic [$clog2(DEPTH+1)-1:0]   fill_o
);

  localparam int FW     = $clog2(DEPTH + 1);
  localparam int DVW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int WORD_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;

  state_t           r_state, w_state_nxt;
  xstep_t           r_xstep, w_xstep_nxt;
  logic [FW-1:0]    r_fill, w_fill_nxt, w_fill_inc;
  logic [DVW-1:0]   r_div, w_div_nxt;
  logic             r_pend, w_pend_nxt;
  logic [CMD_W-1:0] r_pend_cmd, w_pend_cmd_nxt;

  logic              w_load;
  logic              w_sel_data;
  logic [WORD_W-1:0] w_word;
  logic              w_busy;
  logic              w_last;

  assign w_fill_inc = r_fill + FW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_xstep    <= XS_START;
      r_fill     <= '0;
      r_div      <= '0;
      r_pend     <= 1'b0;
      r_pend_cmd <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_xstep    <= w_xstep_nxt;
      r_fill     <= w_fill_nxt;
      r_div      <= w_div_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_cmd <= w_pend_cmd_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_xstep_nxt    = r_xstep;
    w_fill_nxt     = r_fill;
    w_div_nxt      = r_div;
    w_pend_nxt     = r_pend;
    w_pend_cmd_nxt = r_pend_cmd;
    w_load         = 1'b0;
    w_sel_data     = 1'b0;
    w_word         = '0;
    case (r_state)
      ST_IDLE: begin
        w_fill_nxt = '0;
        w_div_nxt  = '0;
        w_pend_nxt = 1'b0;
        if (start_i) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // A queued command or a frame in flight freezes both fill and divider.
        if (r_pend) begin
          w_load     = 1'b1;
          w_word     = WORD_W'(r_pend_cmd);
          w_pend_nxt = 1'b0;
        end else if (!w_busy) begin
          if (r_fill == FW'(DEPTH)) begin
            w_xstep_nxt = XS_START;
            w_state_nxt = peer_ready_i ? ST_TRANSFER : ST_STANDBY;
          end else if (r_div == DVW'(DIV - 1)) begin
            w_div_nxt  = '0;
            w_fill_nxt = w_fill_inc;
            // Fill only ever rises by one, so each level is queued exactly once.
            if (w_fill_inc == FW'(THR_READY)) begin
              w_pend_nxt     = 1'b1;
              w_pend_cmd_nxt = CMD_W'(CMD_READY);
            end else if (w_fill_inc == FW'(THR_START)) begin
              w_pend_nxt     = 1'b1;
              w_pend_cmd_nxt = CMD_W'(CMD_START);
            end else if (w_fill_inc == FW'(DEPTH)) begin
              w_pend_nxt     = 1'b1;
              w_pend_cmd_nxt = CMD_W'(CMD_FULL);
            end
          end else begin
            w_div_nxt = r_div + DVW'(1);
          end
        end
      end
      ST_STANDBY: begin
        if (peer_ready_i || peer_half_i) begin
          w_xstep_nxt = XS_START;
          w_state_nxt = ST_TRANSFER;
        end
      end
      ST_TRANSFER: begin
        case (r_xstep)
          XS_START: begin
            if (peer_half_i) begin
              w_fill_nxt  = '0;
              w_div_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_load      = 1'b1;
              w_word      = WORD_W'(CMD_W'(CMD_DATA));
              w_xstep_nxt = XS_CMD;
            end
          end
          XS_CMD: begin
            // Chain the data frame onto the last bit; peer_half_i no longer matters.
            if (w_last) begin
              w_load      = 1'b1;
              w_sel_data  = 1'b1;
              w_word      = WORD_W'(r_fill);
              w_xstep_nxt = XS_DATA;
            end
          end
          default: begin
            if (w_last) begin
              w_fill_nxt  = '0;
              w_div_nxt   = '0;
              w_xstep_nxt = XS_START;
              w_state_nxt = ST_IDLE;
            end
          end
        endcase
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  scan_link_ser_tx #(
    .CMD_W  (CMD_W),
    .DATA_W (DATA_W),
    .WORD_W (WORD_W)
  ) u_ser_tx (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_sel_data (w_sel_data),
    .i_word     (w_word),
    .o_busy     (w_busy),
    .o_last     (w_last),
    .o_ser_clk  (ser_clk_o),
    .o_ser_data (ser_data_o)
  );

  assign ser_busy_o = w_busy;
  assign state_o    = r_state;
  assign fill_o     = r_fill;

endmodule

// File: tb/tb_scan_link_ctrl.sv
// tb_scan_link_ctrl
//   Scoreboard bench for scan_link_ctrl (DEPTH=10, DIV=4). Stimulus pushes
//   the frames the link should carry; a monitor decodes the serial line
//   and pops/compares each completed frame, including fill at frame start
//   and start-to-start spacing. Honours SCAN_LINK_PARITY_EN.
module tb_scan_link_ctrl;

  localparam int DEPTH = 10, THR_READY = 7, THR_START = 8, DIV = 4;
  localparam int CMD_W = 8, DATA_W = 8;
`ifdef SCAN_LINK_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FC_CMD = 2 * (CMD_W + PB);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0, peer_ready_i = 1'b0, peer_half_i = 1'b0;
  logic ser_clk_o, ser_data_o, ser_busy_o;
  logic [1:0] state_o;
  logic [3:0] fill_o;

  always #5 clk = ~clk;

  scan_link_ctrl #(
    .DEPTH(DEPTH), .THR_READY(THR_READY), .THR_START(THR_START),
    .DIV(DIV), .CMD_W(CMD_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .peer_ready_i(peer_ready_i),
    .peer_half_i(peer_half_i), .ser_clk_o(ser_clk_o), .ser_data_o(ser_data_o),
    .ser_busy_o(ser_busy_o), .state_o(state_o), .fill_o(fill_o)
  );

  typedef struct {
    logic [31:0] val;
    int          len;
    int          fill;
    int          gap;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_abort = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Expected frame: payload LSB first, optional even parity above it.
  task automatic push_frame(input int code, input int w, input int fill, input int gap);
    exp_t e;
    logic [31:0] v;
    v = 32'(code);
    if (PB == 1) v = v | (32'(^v) << w);
    e.val = v; e.len = w + PB; e.fill = fill; e.gap = gap;
    sb_q.push_back(e);
  endtask

  // Monitor: samples 1 time unit after every rising edge.
  initial begin : monitor
    int bitcnt = 0;
    bit ph = 1'b0;
    bit rogue = 1'b0;
    logic d0 = 1'b0;
    logic [31:0] sh = '0;
    longint cyc = 0, last_start = -100000;
    exp_t cur;
    cur.val = '0; cur.len = 1; cur.fill = -1; cur.gap = -1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (mon_abort) begin
        sb_q.delete();
        bitcnt = 0; ph = 1'b0; sh = '0; rogue = 1'b0;
        mon_abort = 1'b0;
      end else if (ser_busy_o === 1'b1) begin
        if (!ph && bitcnt == 0 && !rogue) begin
          if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_frame: got a frame start expected none at %0t", $time);
            rogue = 1'b1;
          end else begin
            cur = sb_q[0];
            check("frame_fill_at_start", fill_o, cur.fill);
            if (cur.gap >= 0) check("frame_start_spacing", cyc - last_start, cur.gap);
            last_start = cyc;
          end
        end
        if (!rogue) begin
          check("ser_clk_phase", ser_clk_o, ph);
          if (!ph) d0 = ser_data_o;
          else begin
            check("ser_data_hold", ser_data_o, d0);
            sh[bitcnt] = ser_data_o;
            bitcnt++;
            if (bitcnt == cur.len) begin
              check("frame_value", sh, cur.val);
              void'(sb_q.pop_front());
              bitcnt = 0; sh = '0;
            end
          end
        end
        ph = ~ph;
      end else begin
        check("idle_ser_clk", ser_clk_o, 1'b0);
        check("idle_ser_data", ser_data_o, 1'b0);
        if (!rogue && (bitcnt != 0 || ph)) begin
          n_checks++; n_fail++;
          $display("FAIL truncated_frame: got %0d bits expected %0d", bitcnt, cur.len);
        end
        bitcnt = 0; ph = 1'b0; sh = '0; rogue = 1'b0;
      end
    end
  end

  task automatic wait_state(input logic [1:0] st, input int limit);
    int n = 0;
    while (state_o !== st && n < limit) begin @(negedge clk); n++; end
    check("wait_state_reached", state_o, st);
  endtask

  task automatic wait_frame(input logic [1:0] st, input int fill, input int limit);
    int n = 0;
    while (!(ser_busy_o === 1'b1 && state_o === st && fill_o === 4'(fill)) && n < limit) begin
      @(negedge clk); n++;
    end
    check("wait_frame_started", ser_busy_o, 1'b1);
  endtask

  task automatic wait_drained(input int limit);
    int n = 0;
    while (sb_q.size() != 0 && n < limit) begin @(negedge clk); n++; end
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  // mode 0: ready at full; 1: standby then release; 2: half mid CMD_DATA;
  // 3: standby then early half (drop); 4: reset during CMD_START bit 4.
  task automatic run_scenario(input int mode, input int hold);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    peer_half_i  = 1'b0;
    peer_ready_i = (mode == 0 || mode == 2) ? 1'b1 : 1'b0;
    push_frame(2, CMD_W, THR_READY, -1);
    push_frame(3, CMD_W, THR_START, FC_CMD + 1 + DIV * (THR_START - THR_READY));
    if (mode != 4) push_frame(4, CMD_W, DEPTH, FC_CMD + 1 + DIV * (DEPTH - THR_START));
    if (mode <= 2) begin
      push_frame(7, CMD_W, DEPTH, -1);
      push_frame(DEPTH, DATA_W, DEPTH, FC_CMD);
    end
    start_i = 1'b1;
    @(negedge clk);
    check("start_to_active", state_o, 2'd1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    start_i = 1'b0;
    case (mode)
      0: wait_state(2'd0, 3000);
      1: begin
        wait_state(2'd2, 3000);
        for (int i = 0; i < hold; i++) begin
          start_i = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        start_i = 1'b0;
        check("standby_held", state_o, 2'd2);
        check("standby_fill", fill_o, DEPTH);
        if ($urandom_range(0, 1) == 1) begin
          peer_half_i = 1'b1; @(negedge clk); peer_half_i = 1'b0;
        end else begin
          peer_ready_i = 1'b1;
        end
        wait_state(2'd0, 3000);
        peer_ready_i = 1'b0;
      end
      2: begin
        wait_frame(2'd3, DEPTH, 3000);
        repeat (4) @(negedge clk);
        peer_half_i = 1'b1;
        repeat (2) @(negedge clk);
        peer_half_i = 1'b0;
        wait_state(2'd0, 3000);
      end
      3: begin
        wait_state(2'd2, 3000);
        peer_ready_i = 1'b1; peer_half_i = 1'b1;
        @(negedge clk);
        check("early_half_in_transfer", state_o, 2'd3);
        @(negedge clk);
        check("early_half_idle", state_o, 2'd0);
        check("early_half_fill", fill_o, 0);
        peer_ready_i = 1'b0; peer_half_i = 1'b0;
        repeat (10) @(negedge clk);
        check("early_half_no_frame", ser_busy_o, 1'b0);
      end
      default: begin
        wait_frame(2'd1, THR_START, 3000);
        repeat (6) @(negedge clk);
        rst = 1'b1; mon_abort = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy", ser_busy_o, 1'b0);
        check("rst_mid_data", ser_data_o, 1'b0);
        check("rst_mid_clk", ser_clk_o, 1'b0);
        check("rst_mid_state", state_o, 2'd0);
        check("rst_mid_fill", fill_o, 0);
        @(negedge clk);
        rst = 1'b0;
      end
    endcase
    wait_drained(200);
    check("end_state_idle", state_o, 2'd0);
    check("end_fill_zero", fill_o, 0);
  endtask

  initial begin : stim
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", state_o, 2'd0);
    check("reset_fill", fill_o, 0);
    check("reset_busy", ser_busy_o, 1'b0);
    check("reset_data", ser_data_o, 1'b0);
    check("reset_clk", ser_clk_o, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_without_start", state_o, 2'd0);
    for (int m = 0; m < 5; m++) run_scenario(m, 50);
    for (int k = 0; k < 6; k++) run_scenario(int'($urandom_range(0, 4)), int'($urandom_range(1, 60)));
    repeat (20) @(negedge clk);
    check("final_queue_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
